uart_rx: RTL

//   UART 8N1 receiver: deserialises the asynchronous rx line into bytes, LSB first.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and baud timing helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4,
    S_BREAK = 3'd5
  } state_e;

  localparam int CNT_W = 16;

  function automatic int clk_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling of the synchronised rx line, LSB first.
//   state   | meaning
//   S_IDLE  | line idle, waiting for a falling edge
//   S_START | timing to the middle of the start bit, rejects glitches
//   S_DATA  | sampling eight data bits at their centres
//   S_STOP  | sampling the stop bit
//   S_DONE  | one cycle: publish byte, pulse rx_done
//   S_BREAK | stop bit was low: pulse frame_error, wait for line high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 9_600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

  logic             rx_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q;
  logic             rx_done_q, frame_error_q;

  // Idle line is high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (clk_cnt_q == HALF_LAST) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (clk_cnt_q == BIT_LAST) begin
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          clk_cnt_d          = '0;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (clk_cnt_q == BIT_LAST) state_d = rx_s ? S_DONE : S_BREAK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_BREAK: begin
        // A held-low line must not look like a new start bit.
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) clk_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_done_q     <= (state_d == S_DONE);
      frame_error_q <= (state_d == S_BREAK) && (state_q != S_BREAK);
      if (state_d == S_DONE) data_out_q <= shift_q;
    end
  end

  assign data_out    = data_out_q;
  assign rx_done     = rx_done_q;
  assign frame_error = frame_error_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule
